replay_fifo: RTL and testbench



---
 rtl/replay_fifo.sv | 151 +++++++++++++++
 tb/tb_replay_fifo.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/replay_fifo.sv
// replay_fifo: synchronous FIFO with a commit/replay read window.
// Entries that have been read stay in storage until a commit releases them.
// A replay rewinds the read pointer to the last commit point, so a consumer
// that restarts its pass can re-read the same words.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// exactly when valid and ready are both high in the cycle before that edge.
// wr_ready and rd_valid depend only on registered state (and, for rd_valid,
// the replay input), never on wr_valid or rd_ready, so producer and consumer
// may hold valid/ready in any pattern without combinational loops.
module replay_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       wr_valid,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    output logic                       wr_ready,
    output logic                       rd_valid,
    output logic [DATA_WIDTH-1:0]      rd_data,
    input  logic                       rd_ready,
    input  logic                       commit,
    input  logic                       replay,
    output logic [$clog2(DEPTH):0]     stored_count,
    output logic [$clog2(DEPTH):0]     pending_count,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic                       underflow
);

    // Address width and pointer width; the extra pointer MSB tells a full
    // window apart from an empty one after the low bits wrap.
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] AF_T    = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_T    = PW'(AE_THRESH);

    // Storage; never reset, so a flush only moves pointers.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Pointer state: write, read and commit pointers.
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] cptr_q, cptr_d;

    // Sticky error flags.
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Derived status, all from pre-edge state.
    logic [PW-1:0] stored;
    logic [PW-1:0] pending;
    logic          full;
    logic          wr_fire;
    logic          rd_fire;

    // Occupancy: modulo-2*DEPTH differences of the pointers.
    always_comb begin
        stored  = wptr_q - cptr_q;
        pending = wptr_q - rptr_q;
        full    = (stored == DEPTH_P);
    end

    // Handshake outputs and accepted transfers.
    always_comb begin
        wr_ready = !full;
        rd_valid = (pending != '0) && !replay;
        wr_fire  = wr_valid && !full;
        rd_fire  = rd_valid && rd_ready;
        rd_data  = mem_q[rptr_q[AW-1:0]];
    end

    // Pointer and flag next-state logic.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        cptr_d      = cptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_fire) begin
            wptr_d = wptr_q + PW'(1);
        end

        // Commit captures the pre-edge read pointer, so a read accepted in
        // the same cycle stays uncommitted.
        if (commit) begin
            cptr_d = rptr_q;
        end

        // Replay alone rewinds to the commit point. With a simultaneous
        // commit the commit point becomes the current read pointer, so the
        // read pointer simply stays where it is.
        if (replay) begin
            if (!commit) begin
                rptr_d = cptr_q;
            end
        end else if (rd_fire) begin
            rptr_d = rptr_q + PW'(1);
        end

        if (wr_valid && full) begin
            overflow_d = 1'b1;
        end
        if (rd_ready && !rd_valid && !replay) begin
            underflow_d = 1'b1;
        end
    end

    // State registers: reset beats clear beats normal operation.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            cptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cptr_q      <= cptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Memory write port; a write coinciding with reset or clear is dropped.
    always_ff @(posedge clk) begin
        if (wr_fire && !reset && !clear) begin
            mem_q[wptr_q[AW-1:0]] <= wr_data;
        end
    end

    // Count, threshold and error outputs.
    always_comb begin
        stored_count  = stored;
        pending_count = pending;
        almost_full   = (stored >= AF_T);
        almost_empty  = (pending <= AE_T);
        overflow      = overflow_q;
        underflow     = underflow_q;
    end

endmodule

// File: tb/tb_replay_fifo.sv
// Testbench for replay_fifo (DEPTH=8, DATA_WIDTH=16, AF=6, AE=1).
// Directed sequences plus a randomly stalled streaming phase; read data is
// checked by a negedge monitor against an expected-data queue.
module tb_replay_fifo;

    localparam int W = 16;
    localparam int D = 8;

    logic         clk;
    logic         reset;
    logic         clear;
    logic         wr_valid;
    logic [W-1:0] wr_data;
    logic         wr_ready;
    logic         rd_valid;
    logic [W-1:0] rd_data;
    logic         rd_ready;
    logic         commit;
    logic         replay;
    logic [3:0]   stored_count;
    logic [3:0]   pending_count;
    logic         almost_full;
    logic         almost_empty;
    logic         overflow;
    logic         underflow;

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] exp_q[$];

    replay_fifo #(.DATA_WIDTH(W), .DEPTH(D), .AF_THRESH(D-2), .AE_THRESH(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_ready     (rd_ready),
        .commit       (commit),
        .replay       (replay),
        .stored_count (stored_count),
        .pending_count(pending_count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!reset && rd_valid && rd_ready) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_data: unexpected read of %0h, expected queue empty", rd_data);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    n_fail++;
                    $display("FAIL rd_data: got %0h expected %0h", rd_data, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clear    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        commit   = 1'b0;
        replay   = 1'b0;
    endtask

    task automatic do_write(input logic [W-1:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [W-1:0] e);
        exp_q.push_back(e);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Expected state right after a reset or clear.
    task automatic chk_flushed(input string tag);
        chk({tag, " stored_count"},  32'(stored_count),  0);
        chk({tag, " pending_count"}, 32'(pending_count), 0);
        chk({tag, " wr_ready"},      32'(wr_ready),      1);
        chk({tag, " rd_valid"},      32'(rd_valid),      0);
        chk({tag, " almost_empty"},  32'(almost_empty),  1);
        chk({tag, " almost_full"},   32'(almost_full),   0);
        chk({tag, " overflow"},      32'(overflow),      0);
        chk({tag, " underflow"},     32'(underflow),     0);
    endtask

    // Build 5 stored entries with overflow already set: fill, overflow, read 3, commit.
    task automatic setup_five(input logic [W-1:0] base);
        for (int i = 0; i < D; i++) do_write(base + W'(i));
        do_write(16'hDEAD);
        for (int i = 0; i < 3; i++) do_read(base + W'(i));
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("setup stored_count", 32'(stored_count), 5);
        chk("setup overflow",     32'(overflow),     1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk_flushed("reset");

        // Fill/drain with overflow.
        for (int i = 1; i <= D; i++) do_write(W'(i));
        chk("fill wr_ready",     32'(wr_ready),     0);
        chk("fill stored_count", 32'(stored_count), 8);
        chk("fill almost_full",  32'(almost_full),  1);
        do_write(16'hDEAD);
        chk("fill overflow",     32'(overflow),     1);
        chk("fill stored_after_ovf", 32'(stored_count), 8);
        chk("fill rd_data head", 32'(rd_data),      1);
        commit = 1'b1;
        for (int i = 1; i <= D; i++) do_read(W'(i));
        tick();
        commit = 1'b0;
        chk("drain stored_count",  32'(stored_count),  0);
        chk("drain pending_count", 32'(pending_count), 0);
        chk("drain almost_empty",  32'(almost_empty),  1);
        chk("drain underflow",     32'(underflow),     0);
        do_clear();
        chk_flushed("clear1");

        // Replay from the start.
        for (int i = 0; i < 4; i++) do_write(16'h00A0 + W'(i));
        do_read(16'h00A0);
        do_read(16'h00A1);
        replay   = 1'b1;
        rd_ready = 1'b1;
        #1;
        chk("replay rd_valid low", 32'(rd_valid), 0);
        tick();
        replay   = 1'b0;
        rd_ready = 1'b0;
        chk("replay underflow", 32'(underflow), 0);
        for (int i = 0; i < 4; i++) begin
            chk("replay pending_count", 32'(pending_count), 32'(4 - i));
            do_read(16'h00A0 + W'(i));
        end
        chk("replay pending_end", 32'(pending_count), 0);
        chk("replay stored_end",  32'(stored_count),  4);
        do_clear();

        // Commit then replay.
        for (int i = 0; i < 4; i++) do_write(16'h00B0 + W'(i));
        do_read(16'h00B0);
        do_read(16'h00B1);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("cr stored_count", 32'(stored_count), 2);
        do_read(16'h00B2);
        replay = 1'b1;
        tick();
        replay = 1'b0;
        chk("cr pending_count", 32'(pending_count), 2);
        do_read(16'h00B2);
        do_read(16'h00B3);
        do_clear();

        // Commit frees space only on the following cycle.
        for (int i = 0; i < D; i++) do_write(16'hC000 + W'(i));
        for (int i = 0; i < 3; i++) do_read(16'hC000 + W'(i));
        chk("cw wr_ready full", 32'(wr_ready), 0);
        commit   = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 16'hC008;
        tick();
        commit = 1'b0;
        chk("cw stored N",   32'(stored_count), 5);
        chk("cw wr_ready N", 32'(wr_ready),     1);
        chk("cw overflow N", 32'(overflow),     1);
        tick();
        wr_valid = 1'b0;
        chk("cw stored N+1", 32'(stored_count), 6);
        for (int i = 3; i <= 8; i++) do_read(16'hC000 + W'(i));
        do_clear();

        // Underflow: read attempt while empty.
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("underflow set", 32'(underflow), 1);
        do_clear();
        chk("underflow cleared", 32'(underflow), 0);

        // Clear mid-operation with a write pending.
        setup_five(16'hD000);
        clear    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 16'hBEEF;
        tick();
        idle();
        chk_flushed("midclear");

        // Same with reset.
        setup_five(16'hD100);
        reset    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 16'hBEEF;
        tick();
        reset = 1'b0;
        idle();
        chk_flushed("midreset");
        do_write(16'h00E0);
        chk("post-reset rd_valid", 32'(rd_valid),      1);
        chk("post-reset pending",  32'(pending_count), 1);
        do_read(16'h00E0);
        do_clear();

        // Streaming with random stalls across several pointer wraps.
        begin
            int mw, mr, mc, nw, cycles;
            logic wv, rr, cm;
            logic [W-1:0] d;
            mw = 0; mr = 0; mc = 0; nw = 0; cycles = 0;
            while ((nw < 40 || mr < 40) && cycles < 600) begin
                chk("wrap stored_count",  32'(stored_count),  32'(mw - mc));
                chk("wrap pending_count", 32'(pending_count), 32'(mw - mr));
                chk("wrap wr_ready",      32'(wr_ready),      32'((mw - mc) != D));
                chk("wrap rd_valid",      32'(rd_valid),      32'((mw - mr) != 0));
                chk("wrap almost_full",   32'(almost_full),   32'((mw - mc) >= D - 2));
                chk("wrap almost_empty",  32'(almost_empty),  32'((mw - mr) <= 1));
                wv = (nw < 40) && ((mw - mc) < D) && ($urandom_range(0, 3) != 0);
                rr = ((mw - mr) > 0) && ($urandom_range(0, 2) != 0);
                cm = ($urandom_range(0, 3) == 0);
                d  = W'($urandom_range(0, 65535));
                wr_valid = wv;
                wr_data  = d;
                rd_ready = rr;
                commit   = cm;
                if (wv) begin
                    exp_q.push_back(d);
                    nw++;
                end
                if (cm) mc = mr;
                if (rr) mr++;
                if (wv) mw++;
                tick();
                cycles++;
            end
            idle();
            chk("wrap finished in budget", 32'(cycles < 600), 1);
            commit = 1'b1;
            tick();
            commit = 1'b0;
            chk("wrap final stored", 32'(stored_count), 0);
            chk("wrap overflow",     32'(overflow),     0);
            chk("wrap underflow",    32'(underflow),    0);
        end

        tick();
        chk("expected queue drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
